// File: rtl/seg_display_arbiter_pkg.sv
// Shared types, constants and the digit encoder for the segment display arbiter.
package seg_arb_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned SEG_W   = 7;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

    // Active-low segments a..g, bit 6 = a.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b111_1111;

    // Packed so entry N sits at index N (first element listed is index 7).
    localparam logic [NUM_REQ-1:0][SEG_W-1:0] SEG_DIGITS = {
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    function automatic logic [SEG_W-1:0] digit_to_seg(input logic [IDX_W-1:0] digit);
        return SEG_DIGITS[digit];
    endfunction

endpackage

// File: rtl/seg_display_arbiter_rr_pick.sv
// Combinational picker: first set candidate searching downward from an origin,
// wrapping 0 -> 7. In fixed mode the origin is forced to the top index.
module rr_pick
    import seg_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] cand_i,
    input  logic [IDX_W-1:0]   start_i,
    input  logic               rr_mode_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               found_o
);

    logic [IDX_W-1:0] origin_c;

    assign origin_c = rr_mode_i ? start_i : IDX_W'(NUM_REQ - 1);

    // Descending wrap-around scan; the first hit wins.
    always_comb begin
        logic             hit;
        logic [IDX_W-1:0] pos;
        logic [IDX_W-1:0] win;
        hit = 1'b0;
        win = '0;
        pos = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = origin_c - IDX_W'(k);
            if (!hit && cand_i[pos]) begin
                hit = 1'b1;
                win = pos;
            end
        end
        found_o  = hit;
        idx_o    = win;
        winner_o = hit ? (NUM_REQ'(1) << win) : '0;
    end

endmodule

// File: rtl/seg_display_arbiter.sv
// Time-shares one 7-segment digit among 8 requesters with a minimum dwell per grant.
module seg_display_arbiter
    import seg_arb_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter bit          ROUND_ROBIN  = 1'b1
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_id,
    output logic [SEG_W-1:0]   seg
);

    localparam int unsigned     CNT_W   = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   id_q, id_d;
    logic               valid_q, valid_d;
    logic [SEG_W-1:0]   seg_q, seg_d;

    logic               expired_c;
    logic [NUM_REQ-1:0] cand_c;
    logic [IDX_W-1:0]   start_c;
    logic [NUM_REQ-1:0] pick_winner_c;
    logic [IDX_W-1:0]   pick_idx_c;
    logic               pick_found_c;
    logic               take_new_c;
    logic               drop_c;

    assign expired_c = (cnt_q == CNT_MAX);
    // While showing, the current holder is excluded so any other requester can take over.
    assign cand_c    = (state_q == SHOW) ? (req & ~grant_q) : req;
    assign start_c   = ptr_q - IDX_W'(1);

    rr_pick u_pick (
        .cand_i    (cand_c),
        .start_i   (start_c),
        .rr_mode_i (ROUND_ROBIN),
        .winner_o  (pick_winner_c),
        .idx_o     (pick_idx_c),
        .found_o   (pick_found_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and grant/release decision.
    always_comb begin
        state_d    = state_q;
        take_new_c = 1'b0;
        drop_c     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found_c) begin
                    state_d    = SHOW;
                    take_new_c = 1'b1;
                end
            end
            SHOW: begin
                if (expired_c) begin
                    if (pick_found_c) begin
                        take_new_c = 1'b1;
                    end else if (!req[id_q]) begin
                        state_d = IDLE;
                        drop_c  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values for the dwell counter, pointer and registered outputs.
    always_comb begin
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        id_d    = id_q;
        valid_d = valid_q;
        seg_d   = seg_q;
        if (state_q == SHOW && !expired_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (take_new_c) begin
            cnt_d   = '0;
            ptr_d   = pick_idx_c;
            grant_d = pick_winner_c;
            id_d    = pick_idx_c;
            valid_d = 1'b1;
            seg_d   = digit_to_seg(pick_idx_c);
        end else if (drop_c) begin
            cnt_d   = '0;
            grant_d = '0;
            id_d    = '0;
            valid_d = 1'b0;
            seg_d   = SEG_BLANK;
        end
    end

    // Datapath and output registers; all outputs update together so they stay consistent.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            seg_q   <= SEG_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            valid_q <= valid_d;
            seg_q   <= seg_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_id    = id_q;
    assign seg         = seg_q;

endmodule
